maquina_estados_param: RTL
==========================

# maquina_estados_param

Parametrised successor of the FIFO-bank control state machine. Sequences RESET → INIT → IDLE/ACTIVE for a bank of `NUM_FIFOS` FIFOs. Latches the low/high occupancy thresholds during INIT and drives per-FIFO almost-full/almost-empty flags from live occupancy counts. Adds a hysteretic `pause` output for upstream flow control. Sits between the test/config interface and the FIFO bank, next to the demux/mux datapath.

## Interface
Parameters:
- `NUM_FIFOS`, default 8: number of FIFOs monitored.
- `CNT_W`, default 3: width of each occupancy count and of both thresholds.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_L`  in  1  asynchronous, active-low reset.
- `init`  in  1  level; high requests INIT (threshold load).
- `umbral_bajo`  in  CNT_W  low threshold to load.
- `umbral_alto`  in  CNT_W  high threshold to load.
- `empty_fifos`  in  NUM_FIFOS  per-FIFO empty flags.
- `fifo_count`  in  NUM_FIFOS*CNT_W  packed occupancy counts; FIFO i at bits [i*CNT_W +: CNT_W].
- `error_fifos`  in  NUM_FIFOS  per-FIFO overflow/underflow pulses; only present with `MAQ_ERROR_EN`.
- `estado`  out  3  current state.
- `init_out`, `idle_out`, `active_out`  out  1 each  one-hot state indicators.
- `umbral_bajo_out`, `umbral_alto_out`  out  CNT_W  committed thresholds.
- `almost_full`  out  NUM_FIFOS  per-FIFO flag, set when count >= `umbral_alto_out`.
- `almost_empty`  out  NUM_FIFOS  per-FIFO flag, set when count <= `umbral_bajo_out`.
- `pause`  out  1  hysteretic back-pressure to the source.
- `error_out`  out  1  sticky error; only present with `MAQ_ERROR_EN`.
- `error_id`  out  NUM_FIFOS  captured `error_fifos` snapshot; only present with `MAQ_ERROR_EN`.

## Operation
- States: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4. Any other encoding goes to RESET.
- `reset_L` low forces, asynchronously:
  - `estado`=RESET.
  - Every output = 0.
  - Shadow threshold registers = 0.
- RESET: goes to INIT on the first edge after `reset_L` deasserts.
- INIT:
  - While `init`=1, capture `umbral_bajo`/`umbral_alto` into shadow registers every cycle.
  - When `init`=0, commit shadows to the `*_out` thresholds and go to IDLE.
  - If shadow bajo > shadow alto at commit, commit `umbral_bajo_out` = shadow alto (clamp).
- IDLE and ACTIVE, next state by priority:
  - any `error_fifos` bit → ERROR;
  - else `init`=1 → INIT (thresholds retained until the next commit);
  - else `empty_fifos` all ones → IDLE;
  - else → ACTIVE.
- ERROR:
  - `error_id` captures `error_fifos` on entry and holds.
  - `init`=1 → INIT, which clears `error_out` and `error_id`.
  - Otherwise stay in ERROR.
- State indicators: `init_out`, `idle_out` and `active_out` are registered with `estado`; exactly one is high in INIT/IDLE/ACTIVE, all are low in RESET/ERROR.
- Flags:
  - `almost_full` and `almost_empty` are evaluated only in IDLE/ACTIVE; forced to 0 in the other states.
  - Comparisons are unsigned, CNT_W bits.
- `pause`:
  - Sets when any `almost_full` condition is true.
  - Clears only when every count <= `umbral_bajo_out`.
  - Otherwise holds.
  - Forced to 0 outside IDLE/ACTIVE; asserted in ERROR.

## Timing
- All outputs are registered with 1-cycle latency: inputs sampled at edge N appear at N+1.
- Threshold commit: the INIT→IDLE edge updates `umbral_*_out` and `estado` together. Flags use the new thresholds from the following edge.
- Simultaneous events:
  - error and `init` in the same cycle: ERROR wins.
  - `init`=1 with all FIFOs empty: INIT wins.
- `reset_L` asserted mid-operation takes effect immediately, with no clock required. Deassertion is synchronised by the user; the first active edge after release moves RESET→INIT.
- `umbral_alto_out`=0 makes `almost_full` permanently 1. This is legal and is not an error.

## Configuration
- `MAQ_ERROR_EN` defined: ERROR state, `error_fifos`, `error_out` and `error_id` are present, behaving as above.
- `MAQ_ERROR_EN` undefined:
  - Those ports are absent.
  - ERROR is unreachable; encoding 4 is treated as illegal and goes to RESET.
  - `pause` depends only on the thresholds.

## Test plan
- Reset/init load: pulse `reset_L` low; `init`=1 for 3 cycles with bajo=1, alto=6; then `init`=0 → `estado`=2, `idle_out`=1, thresholds 1/6 one cycle after `init` falls.
- Activity: from IDLE, `empty_fifos`=8'hFE → ACTIVE next edge; back to 8'hFF → IDLE next edge.
- Hysteresis: FIFO 3 count ramps 0→6 → `almost_full[3]` and `pause` = 1. Count falls to 4 → `pause` stays 1. Count 1 → `pause` = 0 and `almost_empty[3]` = 1.
- Clamp: load bajo=7, alto=2 → `umbral_bajo_out`=2, `umbral_alto_out`=2.
- Error (`MAQ_ERROR_EN`): `error_fifos`=8'h10 together with `init`=1 in ACTIVE → `estado`=4, `error_id`=8'h10, `pause`=1. A later `init` pulse → INIT with `error_out`=0.
- Async reset mid-ACTIVE: drop `reset_L` between edges → all outputs 0 immediately; RESET→INIT on the first edge after release.

Source files
------------

// File: rtl/maquina_estados_param.sv
// ---------------------------------------------------------------------------
// maquina_estados_param
//
// Control state machine for a bank of NUM_FIFOS FIFOs. It walks
// RESET -> INIT -> IDLE/ACTIVE. It latches the low/high occupancy thresholds
// during INIT and turns the live per-FIFO occupancy counts into
// almost-full / almost-empty flags. It also drives a hysteretic "pause"
// back-pressure signal towards the upstream source.
//
// Optional feature macro: MAQ_ERROR_EN
//   defined   -> the ERROR state and the error_fifos / error_out / error_id
//                ports exist.
//   undefined -> those ports are absent. Encoding 4 is illegal and recovers
//                to RESET.
//
// Parameters
//   NUM_FIFOS     number of FIFOs monitored (default 8)
//   CNT_W         width of each occupancy count and of both thresholds
//                 (default 3)
//
// Ports
//   clk             single clock, rising edge
//   reset_L         asynchronous active-low reset
//   init            level request for INIT (threshold load)
//   umbral_bajo     low threshold to load
//   umbral_alto     high threshold to load
//   empty_fifos     per-FIFO empty flags
//   fifo_count      packed counts, FIFO i at [i*CNT_W +: CNT_W]
//   error_fifos     per-FIFO error pulses            (MAQ_ERROR_EN only)
//   estado          current state encoding
//   init_out        one-hot indicator for INIT
//   idle_out        one-hot indicator for IDLE
//   active_out      one-hot indicator for ACTIVE
//   umbral_bajo_out committed low threshold
//   umbral_alto_out committed high threshold
//   almost_full     per-FIFO count >= umbral_alto_out
//   almost_empty    per-FIFO count <= umbral_bajo_out
//   error_out       sticky error indicator            (MAQ_ERROR_EN only)
//   error_id        error_fifos snapshot on entry     (MAQ_ERROR_EN only)
//   pause           hysteretic back-pressure
// ---------------------------------------------------------------------------
module maquina_estados_param #(
    parameter int NUM_FIFOS = 8,
    parameter int CNT_W     = 3
) (
    input  logic                       clk,
    input  logic                       reset_L,
    input  logic                       init,
    input  logic [CNT_W-1:0]           umbral_bajo,
    input  logic [CNT_W-1:0]           umbral_alto,
    input  logic [NUM_FIFOS-1:0]       empty_fifos,
    input  logic [NUM_FIFOS*CNT_W-1:0] fifo_count,
`ifdef MAQ_ERROR_EN
    input  logic [NUM_FIFOS-1:0]       error_fifos,
    output logic                       error_out,
    output logic [NUM_FIFOS-1:0]       error_id,
`endif
    output logic [2:0]                 estado,
    output logic                       init_out,
    output logic                       idle_out,
    output logic                       active_out,
    output logic [CNT_W-1:0]           umbral_bajo_out,
    output logic [CNT_W-1:0]           umbral_alto_out,
    output logic [NUM_FIFOS-1:0]       almost_full,
    output logic [NUM_FIFOS-1:0]       almost_empty,
    output logic                       pause
);

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    state_t               state;
    state_t               next_state;

    logic [CNT_W-1:0]     shadow_bajo;
    logic [CNT_W-1:0]     shadow_alto;
    logic [CNT_W-1:0]     commit_bajo;

    logic [NUM_FIFOS-1:0] full_cond;
    logic [NUM_FIFOS-1:0] empty_cond;
    logic                 any_full;
    logic                 all_low;
    logic                 op_now;
    logic                 op_next;
    logic                 flags_live;

    assign estado = state;

    // Per-FIFO threshold comparisons against the committed thresholds.
    // Both compares are unsigned and CNT_W wide. A high threshold of zero
    // therefore makes every FIFO look almost full. That case is legal.
    always_comb begin
        full_cond  = '0;
        empty_cond = '0;
        for (int i = 0; i < NUM_FIFOS; i++) begin
            full_cond[i]  = (fifo_count[i*CNT_W +: CNT_W] >= umbral_alto_out);
            empty_cond[i] = (fifo_count[i*CNT_W +: CNT_W] <= umbral_bajo_out);
        end
    end

    assign any_full = |full_cond;
    assign all_low  = &empty_cond;

    // Flags are only meaningful while the machine is operating. They need
    // both the current and the next state in IDLE/ACTIVE. This keeps them
    // at zero on the INIT->IDLE commit edge, so the first evaluated flags
    // see the freshly committed thresholds. It also keeps them at zero on
    // the edge that leaves IDLE/ACTIVE.
    assign op_now     = (state == ST_IDLE) || (state == ST_ACTIVE);
    assign op_next    = (next_state == ST_IDLE) || (next_state == ST_ACTIVE);
    assign flags_live = op_now && op_next;

    // A low threshold above the high one would make the hysteresis band
    // inverted. In that case the low threshold is clamped down to the high
    // threshold at commit time.
    assign commit_bajo = (shadow_bajo > shadow_alto) ? shadow_alto : shadow_bajo;

    // Next-state logic. In IDLE/ACTIVE an error has priority over an init
    // request. An init request has priority over the all-empty check.
    // Any unused encoding recovers to RESET.
    always_comb begin
        next_state = ST_RESET;
        case (state)
            ST_RESET: begin
                next_state = ST_INIT;
            end
            ST_INIT: begin
                if (init) begin
                    next_state = ST_INIT;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            ST_IDLE, ST_ACTIVE: begin
`ifdef MAQ_ERROR_EN
                if (|error_fifos) begin
                    next_state = ST_ERROR;
                end else if (init) begin
`else
                if (init) begin
`endif
                    next_state = ST_INIT;
                end else if (&empty_fifos) begin
                    next_state = ST_IDLE;
                end else begin
                    next_state = ST_ACTIVE;
                end
            end
`ifdef MAQ_ERROR_EN
            ST_ERROR: begin
                if (init) begin
                    next_state = ST_INIT;
                end else begin
                    next_state = ST_ERROR;
                end
            end
`endif
            default: begin
                next_state = ST_RESET;
            end
        endcase
    end

    // State register together with the one-hot state indicators. The
    // indicators are decoded from next_state so that they line up with
    // estado on the same edge.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state      <= ST_RESET;
            init_out   <= 1'b0;
            idle_out   <= 1'b0;
            active_out <= 1'b0;
        end else begin
            state      <= next_state;
            init_out   <= (next_state == ST_INIT);
            idle_out   <= (next_state == ST_IDLE);
            active_out <= (next_state == ST_ACTIVE);
        end
    end

    // Threshold handling. While INIT is held, the inputs are captured into
    // the shadow registers every cycle. The edge that leaves INIT commits
    // the shadows to the visible outputs. Outside INIT the committed
    // values are retained.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            shadow_bajo     <= '0;
            shadow_alto     <= '0;
            umbral_bajo_out <= '0;
            umbral_alto_out <= '0;
        end else if (state == ST_INIT) begin
            if (init) begin
                shadow_bajo <= umbral_bajo;
                shadow_alto <= umbral_alto;
            end else begin
                umbral_bajo_out <= commit_bajo;
                umbral_alto_out <= shadow_alto;
            end
        end
    end

    // Registered occupancy flags. They are cleared whenever the machine is
    // not operating.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            almost_full  <= '0;
            almost_empty <= '0;
        end else if (flags_live) begin
            almost_full  <= full_cond;
            almost_empty <= empty_cond;
        end else begin
            almost_full  <= '0;
            almost_empty <= '0;
        end
    end

    // Hysteretic back-pressure. Pause sets as soon as any FIFO reaches the
    // high threshold. It releases only once every FIFO has drained to the
    // low threshold. In between, it keeps its previous value. Entering or
    // sitting in ERROR forces pause high so the source stops feeding a
    // faulty bank.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            pause <= 1'b0;
`ifdef MAQ_ERROR_EN
        end else if (next_state == ST_ERROR) begin
            pause <= 1'b1;
`endif
        end else if (flags_live) begin
            if (any_full) begin
                pause <= 1'b1;
            end else if (all_low) begin
                pause <= 1'b0;
            end
        end else begin
            pause <= 1'b0;
        end
    end

`ifdef MAQ_ERROR_EN
    // Error capture. The error_fifos snapshot is taken only on the edge
    // that enters ERROR, then held while the machine stays there. Any
    // other destination (in practice INIT) clears both error outputs.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            error_out <= 1'b0;
            error_id  <= '0;
        end else if (next_state == ST_ERROR) begin
            if (state != ST_ERROR) begin
                error_out <= 1'b1;
                error_id  <= error_fifos;
            end
        end else begin
            error_out <= 1'b0;
            error_id  <= '0;
        end
    end
`endif

endmodule
